// File: rtl/pcm_fetch_pkg.sv
// pcm_fetch_pkg: shared widths, FSM states, line record and byte helpers for the PCM fetch arbiter.
package pcm_fetch_pkg;
  localparam int ROM_ADDR_W = 18;
  localparam int ROM_LINE_W = 64;
  localparam int OFS_W = 3;
  localparam int TAG_W = ROM_ADDR_W - OFS_W;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fsm_t;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [ROM_LINE_W-1:0] data;
  } line_t;
  function automatic logic [7:0] byte_sel(input logic [ROM_LINE_W-1:0] line, input logic [OFS_W-1:0] ofs);
    return line[{ofs, 3'b000} +: 8];
  endfunction
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/pcm_line_buf.sv
// pcm_line_buf: one-line tag/valid/data store with hit compare and byte select.
module pcm_line_buf
  import pcm_fetch_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic [TAG_W-1:0]      load_tag,
  input  logic [ROM_LINE_W-1:0] load_data,
  input  logic [TAG_W-1:0]      tag,
  input  logic [OFS_W-1:0]      ofs,
  output logic                  hit,
  output logic [7:0]            rd_byte
);
  line_t line;
  // flush beats a coincident load: the line data is kept but marked invalid
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) line <= '0;
    else begin
      line.valid <= ~flush & (load | line.valid);
      if (load) begin
        line.tag  <= load_tag;
        line.data <= load_data;
      end
    end
  end
  assign hit = line.valid & ~flush & (line.tag == tag);
  assign rd_byte = byte_sel(line.data, ofs);
endmodule

// File: rtl/pcm_fetch_arb.sv
// pcm_fetch_arb: two PCM voices share one 64-bit DDRAM read channel via per-voice line buffers.
// Define PCM_FETCH_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module pcm_fetch_arb
  import pcm_fetch_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int LINE_W = ROM_LINE_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_rd,
  output logic [7:0]        r0_data,
  output logic              r0_rdy,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_rd,
  output logic [7:0]        r1_data,
  output logic              r1_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data,
  output logic              busy
`ifdef PCM_FETCH_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  logic [ADDR_W-1:0] addr [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [7:0] hit_byte [2];
  logic [7:0] data_q [2];
  logic [1:0] rd, pend, hit, accept, fill, rdy;
  fsm_t state;
  logic gnt, rr, pick;
  assign addr[0] = r0_addr;
  assign addr[1] = r1_addr;
  assign rd = {r1_rd, r0_rd};
  assign accept = rd & ~pend;
  assign {r1_rdy, r0_rdy} = rdy;
  assign r0_data = data_q[0];
  assign r1_data = data_q[1];
  assign busy = |pend | (state != IDLE);
  always_comb pick = &pend ? rr : pend[1];
  for (genvar v = 0; v < 2; v++) begin : g_voice
    // the granted voice always matches itself; the other joins the fill when waiting on the same line
    assign fill[v] = (state == WAIT) & mem_ack & pend[v]
                   & (addr_q[v][ADDR_W-1:OFS_W] == addr_q[gnt][ADDR_W-1:OFS_W]);
    pcm_line_buf u_buf (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .flush     (flush),
      .load      (fill[v]),
      .load_tag  (addr_q[v][ADDR_W-1:OFS_W]),
      .load_data (mem_data),
      .tag       (addr[v][ADDR_W-1:OFS_W]),
      .ofs       (addr[v][OFS_W-1:0]),
      .hit       (hit[v]),
      .rd_byte   (hit_byte[v])
    );
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= '0;
      rdy      <= '0;
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      state    <= IDLE;
      gnt      <= 1'b0;
      rr       <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pend[i] <= fill[i] ? 1'b0 : pend[i] | (accept[i] & ~hit[i]);
        if (accept[i] & ~hit[i]) addr_q[i] <= addr[i];
        rdy[i] <= fill[i] | (accept[i] & hit[i]);
        if (fill[i]) data_q[i] <= byte_sel(mem_data, addr_q[i][OFS_W-1:0]);
        else if (accept[i] & hit[i]) data_q[i] <= hit_byte[i];
      end
      case (state)
        IDLE: if (|pend) begin
          gnt      <= pick;
          mem_addr <= {addr_q[pick][ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          mem_req  <= 1'b1;
          state    <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (mem_ack) begin
          mem_req <= 1'b0;
          rr      <= ~gnt;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PCM_FETCH_STATS_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt  <= sat_add(hit_cnt, 2'(accept[0] & hit[0]) + 2'(accept[1] & hit[1]));
      miss_cnt <= sat_add(miss_cnt, 2'(accept[0] & ~hit[0]) + 2'(accept[1] & ~hit[1]));
    end
  end
`endif
endmodule

// File: tb/tb_pcm_fetch_arb.sv
// tb_pcm_fetch_arb: scoreboard bench with a transaction-level model of the two-voice line-buffer arbiter.
module tb_pcm_fetch_arb;
  localparam int AW = 18;
  typedef struct {
    logic [7:0] d;
    int due;
  } exp_t;
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic flush_main = 1'b0, flush_rsp = 1'b0, ack_main = 1'b0, ack_rsp = 1'b0;
  logic flush, mem_ack;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0, mem_addr;
  logic r0_rd = 1'b0, r1_rd = 1'b0, r0_rdy, r1_rdy, mem_req, busy;
  logic [7:0] r0_data, r1_data;
  logic [63:0] mem_data = '0;
`ifdef PCM_FETCH_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif
  assign flush = flush_main | flush_rsp;
  assign mem_ack = ack_main | ack_rsp;

  pcm_fetch_arb dut (
    .clk_sys (clk_sys), .reset_n (reset_n), .flush (flush),
    .r0_addr (r0_addr), .r0_rd (r0_rd), .r0_data (r0_data), .r0_rdy (r0_rdy),
    .r1_addr (r1_addr), .r1_rd (r1_rd), .r1_data (r1_data), .r1_rdy (r1_rdy),
    .mem_addr (mem_addr), .mem_req (mem_req), .mem_ack (mem_ack), .mem_data (mem_data),
    .busy (busy)
`ifdef PCM_FETCH_STATS_EN
    , .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
`endif
  );

  initial forever #5 clk_sys = ~clk_sys;

  int cyc = 0, n_chk = 0, n_fail = 0, mhits = 0, mmiss = 0;
  bit [1:0] mpend = '0;
  bit mvalid [2];
  logic [AW-4:0] mtag [2];
  logic [AW-1:0] maddr [2];
  bit mactive = 0, mgnt = 0, mrr = 0, auto_ack = 1, ack_flush = 0;
  exp_t q0[$], q1[$];

  // ROM contents: line 0x10 holds 0x8877665544332211, everything else is a hash of the address
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    logic [7:0] k;
    k = 8'(a[2:0]) + 8'd1;
    if (a[AW-1:3] == 15'd2) return 8'(k * 8'd17);
    return 8'(a[7:0] * 8'd7) ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5a;
  endfunction
  function automatic logic [63:0] line_of(input logic [AW-1:0] a);
    logic [63:0] l;
    for (int k = 0; k < 8; k++) l[8*k +: 8] = mem_byte({a[AW-1:3], 3'(k)});
    return l;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void push(input int v, input logic [7:0] d, input int due);
    if (v == 0) q0.push_back('{d, due});
    else q1.push_back('{d, due});
  endfunction

  // reference model, evaluated on the bench's own stimulus at each rising edge
  initial forever begin
    bit [1:0] p, rdv;
    bit ov [2];
    logic [AW-4:0] ot [2];
    logic [AW-1:0] av [2];
    @(posedge clk_sys);
    cyc++;
    if (!reset_n) begin
      mpend = '0; mactive = 0; mgnt = 0; mrr = 0; mvalid = '{0, 0};
      mhits = 0; mmiss = 0; q0.delete(); q1.delete();
    end else begin
      p = mpend; ov = mvalid; ot = mtag; rdv = {r1_rd, r0_rd};
      av[0] = r0_addr; av[1] = r1_addr;
      if (mactive && ack_rsp) begin
        for (int v = 0; v < 2; v++)
          if (p[v] && maddr[v][AW-1:3] == maddr[mgnt][AW-1:3]) begin
            mpend[v] = 0;
            push(v, mem_byte(maddr[v]), cyc);
            if (!flush) begin
              mvalid[v] = 1;
              mtag[v] = maddr[v][AW-1:3];
            end
          end
        mrr = !mgnt;
        mactive = 0;
      end else if (!mactive && p != 0) begin
        mgnt = (p == 2'b11) ? mrr : p[1];
        mactive = 1;
      end
      if (flush) mvalid = '{0, 0};
      for (int v = 0; v < 2; v++)
        if (rdv[v] && !p[v]) begin
          if (ov[v] && ot[v] == av[v][AW-1:3] && !flush) begin
            push(v, mem_byte(av[v]), cyc);
            mhits++;
          end else begin
            mpend[v] = 1;
            maddr[v] = av[v];
            mmiss++;
          end
        end
      if (flush) begin
        mhits = 0;
        mmiss = 0;
      end
    end
  end

  task automatic mon_voice(input int v, input logic rdy, input logic [7:0] d);
    exp_t e;
    bit due_now;
    due_now = 0;
    if (v == 0 && q0.size() > 0) begin e = q0[0]; due_now = e.due <= cyc; end
    if (v == 1 && q1.size() > 0) begin e = q1[0]; due_now = e.due <= cyc; end
    check($sformatf("rdy%0d", v), rdy, due_now);
    if (due_now) begin
      if (v == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      if (rdy) begin
        check($sformatf("data%0d", v), d, e.d);
        check($sformatf("due%0d", v), cyc, e.due);
      end
    end
  endtask

  initial forever begin
    @(negedge clk_sys);
    if (reset_n) begin
      mon_voice(0, r0_rdy, r0_data);
      mon_voice(1, r1_rdy, r1_data);
      check("mem_req", mem_req, mactive);
      check("busy", busy, (mpend != 0) || mactive);
    end
  end

  // DDRAM responder: acks only once the arbiter is waiting, after a random delay
  initial forever begin
    @(negedge clk_sys);
    if (auto_ack && reset_n && mem_req) begin
      repeat ($urandom_range(1, 3)) @(posedge clk_sys);
      #1;
      check("mem_addr", mem_addr, {maddr[mgnt][AW-1:3], 3'b000});
      mem_data = line_of(maddr[mgnt]);
      ack_rsp = 1;
      flush_rsp = ack_flush;
      @(posedge clk_sys);
      #1;
      ack_rsp = 0;
      flush_rsp = 0;
    end
  end

  task automatic step(input bit e0, input logic [AW-1:0] a0, input bit e1, input logic [AW-1:0] a1, input bit fl);
    @(posedge clk_sys);
    #1;
    r0_rd = e0; r0_addr = a0; r1_rd = e1; r1_addr = a1; flush_main = fl;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, '0, 0);
  endtask
  task automatic wait_quiet(input int limit);
    int w;
    w = 0;
    idle(1);
    while (w < limit && !(q0.size() == 0 && q1.size() == 0 && !mactive && mpend == 0)) begin
      idle(1);
      w++;
    end
    idle(2);
    check("drain", w < limit, 1);
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_r0_rdy", r0_rdy, 0);
    check("rst_r1_rdy", r1_rdy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_r0_data", r0_data, 0);
    check("rst_r1_data", r1_data, 0);
    reset_n = 1;
    step(1, 18'h00013, 0, '0, 0); wait_quiet(50);
    step(1, 18'h00017, 0, '0, 0); wait_quiet(50);
    step(1, 18'h00100, 1, 18'h00208, 0); wait_quiet(80);
    step(1, 18'h00110, 1, 18'h00218, 0); wait_quiet(80);
    step(1, 18'h00300, 1, 18'h00305, 0); wait_quiet(50);
    step(0, '0, 0, '0, 1);
    step(1, 18'h00017, 0, '0, 0); wait_quiet(50);
    ack_flush = 1;
    step(0, '0, 1, 18'h00040, 0); wait_quiet(50);
    ack_flush = 0;
    step(0, '0, 1, 18'h00041, 0); wait_quiet(50);
    auto_ack = 0;
    step(1, 18'h00013, 0, '0, 0);
    idle(1);
    w = 0;
    while (w < 20 && !mem_req) begin
      @(negedge clk_sys);
      w++;
    end
    check("req_before_reset", mem_req, 1);
    @(posedge clk_sys);
    #2 reset_n = 0;
    #1;
    check("reset_mem_req", mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_r0_rdy", r0_rdy, 0);
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1;
    @(posedge clk_sys);
    #1 ack_main = 1;
    @(posedge clk_sys);
    #1 ack_main = 0;
    idle(3);
    auto_ack = 1;
    step(1, 18'h00013, 0, '0, 0); wait_quiet(50);
    repeat (400)
      step($urandom_range(0, 2) == 0, 18'h00400 + 18'($urandom_range(0, 5) * 8) + 18'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 18'h00400 + 18'($urandom_range(0, 5) * 8) + 18'($urandom_range(0, 7)),
           $urandom_range(0, 40) == 0);
    wait_quiet(200);
`ifdef PCM_FETCH_STATS_EN
    check("hit_cnt", hit_cnt, mhits);
    check("miss_cnt", miss_cnt, mmiss);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
